// File: rtl/mips_mc_sequencer.sv
// Multi-cycle FETCH/LOAD/DECODE/EXEC/WAIT/WB sequencer for the custom MIPS core.
// Owns the PC, the IR and every ALU/regfile strobe; the shared ALU is driven via start/done.
module mips_mc_sequencer #(
  parameter int unsigned       DATA_W      = 32,
  parameter logic [DATA_W-1:0] PC_RESET    = '0,
  parameter logic [5:0]        J_OPCODE    = 6'b000010,
  parameter logic [5:0]        HALT_OPCODE = 6'b111111
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_en,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_din1,
  output logic [DATA_W-1:0] alu_din2,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_dout,
  output logic [DATA_W-1:0] pc,
  output logic              illegal,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_LOAD, S_DECODE, S_EXEC, S_WAIT, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_BRANCH, K_JUMP, K_HALT, K_ILLEGAL
  } kind_t;

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [3:0]        r_alu_ctrl;
  logic [DATA_W-1:0] r_din1, r_din2, r_result;
  logic              r_illegal, r_is_branch, r_invert;

  kind_t             w_kind;
  logic [3:0]        w_ctrl;
  logic [DATA_W-1:0] w_din2;
  logic              w_invert;
  logic [5:0]        w_opcode;
  logic [DATA_W-1:0] w_imm, w_pc_inc;
  logic              w_taken;

  assign w_opcode = r_ir[31:26];
  assign w_imm    = DATA_W'(r_ir[15:0]);
  assign w_pc_inc = r_pc + DATA_W'(4);
  assign w_taken  = r_result[0] ^ r_invert;

  always_comb begin
    // NOTE: every decode output is defaulted first so no path can infer a latch.
    w_kind   = K_ILLEGAL;
    w_ctrl   = '0;
    w_din2   = rf_rdata2;
    w_invert = 1'b0;
    if (w_opcode == J_OPCODE) begin
      w_kind = K_JUMP;
    end else if (w_opcode == HALT_OPCODE) begin
      w_kind = K_HALT;
    end else if (w_opcode == 6'b000000) begin
      w_ctrl = r_ir[3:0];
      casez (r_ir[3:0])
        4'b00??, 4'b10??, 4'b010?: w_kind = K_ALU;
        4'b111?: begin
          w_kind = K_ALU;
          w_din2 = DATA_W'(r_ir[10:7]);
        end
        default: w_kind = K_ILLEGAL;
      endcase
    end else if (w_opcode[5:4] == 2'b01) begin
      w_ctrl = w_opcode[3:0];
      w_din2 = w_imm;
      casez (w_opcode[3:0])
        4'b011?, 4'b110?: w_kind = K_ILLEGAL;
        default:          w_kind = K_ALU;
      endcase
    end else if (w_opcode[5:3] == 3'b001) begin
      // Inverted branches reuse the positive compare and flip the ALU's bit 0.
      w_kind = K_BRANCH;
      case (w_opcode[2:0])
        3'b000: w_ctrl = 4'b0110;
        3'b001: begin w_ctrl = 4'b0110; w_invert = 1'b1; end
        3'b010: begin w_ctrl = 4'b0110; w_din2 = '0; end
        3'b011: begin w_ctrl = 4'b0110; w_din2 = '0; w_invert = 1'b1; end
        3'b100: w_ctrl = 4'b0100;
        3'b101: w_ctrl = 4'b0101;
        3'b110: begin w_ctrl = 4'b0100; w_din2 = '0; w_invert = 1'b1; end
        3'b111: begin w_ctrl = 4'b0101; w_din2 = '0; w_invert = 1'b1; end
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_LOAD;
      S_LOAD:   w_next = S_DECODE;
      S_DECODE: begin
        case (w_kind)
          K_ALU, K_BRANCH: w_next = S_EXEC;
          K_HALT:          w_next = S_HALT;
          default:         w_next = S_FETCH;
        endcase
      end
      S_EXEC:   w_next = S_WAIT;
      S_WAIT:   if (alu_done) w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_pc        <= PC_RESET;
      r_ir        <= '0;
      r_alu_ctrl  <= '0;
      r_din1      <= '0;
      r_din2      <= '0;
      r_result    <= '0;
      r_illegal   <= 1'b0;
      r_is_branch <= 1'b0;
      r_invert    <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: r_ir <= imem_rdata;
        S_DECODE: begin
          case (w_kind)
            K_ALU, K_BRANCH: begin
              r_alu_ctrl  <= w_ctrl;
              r_din1      <= rf_rdata1;
              r_din2      <= w_din2;
              r_is_branch <= (w_kind == K_BRANCH);
              r_invert    <= w_invert;
            end
            K_JUMP: r_pc <= DATA_W'(r_ir[25:0]);
            K_ILLEGAL: begin
              r_illegal <= 1'b1;
              r_pc      <= w_pc_inc;
            end
            default: ;
          endcase
        end
        S_WAIT: if (alu_done) r_result <= alu_dout;
        S_WB:   r_pc <= (r_is_branch && w_taken) ? w_imm : w_pc_inc;
        default: ;
      endcase
    end
  end

  // imem_en is gated by rst_n because the reset state is FETCH itself.
  assign imem_en   = (r_state == S_FETCH) && rst_n;
  assign imem_addr = r_pc;
  assign rf_raddr1 = r_ir[20:16];
  assign rf_raddr2 = r_ir[15:11];
  assign rf_we     = (r_state == S_WB) && !r_is_branch;
  assign rf_waddr  = r_ir[25:21];
  assign rf_wdata  = r_result;
  assign alu_ctrl  = r_alu_ctrl;
  assign alu_din1  = r_din1;
  assign alu_din2  = r_din2;
  assign alu_start = (r_state == S_EXEC);
  assign pc        = r_pc;
  assign illegal   = r_illegal;
  assign halted    = (r_state == S_HALT);

endmodule

// File: doc/mips_mc_sequencer.md
Name: mips_mc_sequencer

Overview:
Multi-cycle instruction sequencer for the custom MIPS core. Fetches a 32-bit instruction, decodes it, reads the register file, and drives the shared ALU through a start/done handshake. It then writes the ALU result back, or resolves a branch or jump by updating the PC. It is the clocked replacement for the combinational decode path and owns the PC, the IR and all ALU/regfile strobes.

Parameters:
DATA_W, 32, datapath and PC width
PC_RESET, 0, PC value loaded on reset
J_OPCODE, 6'b000010, opcode of absolute jump
HALT_OPCODE, 6'b111111, opcode that stops the sequencer

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
imem_en  out  1  instruction read strobe (FETCH only)
imem_addr  out  DATA_W  fetch address (= pc)
imem_rdata  in  32  instruction word, valid the cycle after imem_en
rf_raddr1  out  5  = ir[20:16] (rsrc1)
rf_raddr2  out  5  = ir[15:11] (rsrc2)
rf_rdata1  in  DATA_W  async read data, port 1
rf_rdata2  in  DATA_W  async read data, port 2
rf_we  out  1  regfile write strobe, one cycle
rf_waddr  out  5  = ir[25:21] (rdst)
rf_wdata  out  DATA_W  writeback value
alu_ctrl  out  4  ALU operation, registered
alu_din1  out  DATA_W  ALU operand 1, registered
alu_din2  out  DATA_W  ALU operand 2, registered
alu_start  out  1  one-cycle start pulse
alu_done  in  1  result valid; earliest 1 cycle after alu_start
alu_dout  in  DATA_W  ALU result, sampled when alu_done=1
pc  out  DATA_W  current PC
illegal  out  1  sticky flag: an undecodable instruction was seen
halted  out  1  high in HALT state

Behaviour:
- Reset (async, rst_n=0): state=FETCH, pc=PC_RESET, ir=0, alu_ctrl/din1/din2=0, result=0. All strobes (imem_en, rf_we, alu_start) are 0; illegal=0, halted=0. Reset mid-instruction aborts the instruction with no write.
- FETCH: imem_en=1, imem_addr=pc -> LOAD.
- LOAD: ir<=imem_rdata -> DECODE.
- DECODE, by opcode=ir[31:26]:
  - 000000 R-type: alu_ctrl=ir[3:0]; din1=rf_rdata1.
    - ctrl 00xx/10xx/010x: din2=rf_rdata2.
    - ctrl 111x: din2=zero-extended shamt ir[10:7].
    - any other ctrl: illegal.
  - 01xxxx immediate: alu_ctrl=opcode[3:0]; din1=rf_rdata1; din2=zero-extended ir[15:0]. Ctrl 0110, 0111, 110x are illegal.
  - 001xxx branch; target = zero-extended ir[15:0].
    - beq/bneq: ctrl 0110, din1=rs1, din2=rs2.
    - bez/bnez: ctrl 0110, din2=0.
    - blt: ctrl 0100, rs1,rs2. bgt: ctrl 0101, rs1,rs2.
    - bgez: ctrl 0100, din2=0, inverted. blez: ctrl 0101, din2=0, inverted.
    - bneq and bnez are inverted.
  - J_OPCODE: pc<=zero-extended ir[25:0] -> FETCH (no ALU use).
  - HALT_OPCODE -> HALT.
  - Anything else, or illegal ctrl: illegal<=1, pc<=pc+4 -> FETCH.
  - ALU and branch instructions -> EXEC.
- EXEC: alu_start=1 for exactly one cycle -> WAIT.
- WAIT: hold operands and alu_ctrl stable. When alu_done=1, result<=alu_dout -> WB. No timeout. alu_done outside WAIT is ignored.
- WB:
  - ALU class: rf_we=1, rf_wdata=result, rf_waddr=rdst; pc<=pc+4.
  - Branch class: taken = result[0] XOR invert; pc <= taken ? target : pc+4. rf_we stays 0.
  - -> FETCH.
- HALT: all strobes 0, halted=1, pc frozen. Exit only by reset.
- Arithmetic: pc+4 wraps modulo 2^DATA_W. pc is not checked for alignment.
- Latency: ALU/branch instruction = 5 + (WAIT cycles) clocks; 6 with single-cycle done. Jump/illegal = 3 clocks.
- rf_we, alu_start and imem_en are never asserted together. Each is a single-cycle pulse per instruction.

Test Plan:
1. Reset, then R-type ADD. rf_rdata1=5, rf_rdata2=7, done 1 cycle after start, alu_dout=12 -> alu_ctrl=0000 at start; rf_we in cycle 5 with wdata=12, waddr=rdst; pc 0->4; next imem_en in cycle 6.
2. Immediate op 010001 with ir[15:0]=16'hFFFF, done delayed 4 cycles -> din2=32'h0000FFFF, held stable through WAIT; single rf_we; total 9 cycles.
3. beq with rs1=rs2, alu_dout=1, target 16'h0040 -> pc=0x40, no rf_we. Repeat with bneq -> pc=pc+4. Repeat with bgez and alu_dout=0 -> pc=0x40.
4. Opcode 000010, ir[25:0]=26'h100 -> pc=0x100 after 3 cycles, no alu_start.
5. Opcode 000000 with funct[3:0]=0110, then opcode 110011 -> illegal=1 and stays 1, pc advances by 4 each time, no rf_we, no alu_start.
6. rst_n low during WAIT -> all outputs at reset values immediately; a late alu_done is ignored. Then HALT_OPCODE -> halted=1, pc frozen for 20 cycles.
